core_control: RTL and testbench
===============================

CORE_CONTROL -- requirements
Module: core_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of cycles to wait for a memory handshake before trapping (range 2..255).
REQ-002 SHALL have ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- instr_i  input  32  fetched instruction, valid only when imem_ready_i=1
- imem_req_o  output  1  instruction fetch request
- imem_ready_i  input  1  fetch complete
- dmem_req_o  output  1  data access request
- dmem_we_o  output  1  data access is a store
- dmem_ready_i  input  1  data access complete
- branch_taken_i  input  1  ALU compare result
- ir_we_o  output  1  instruction register load strobe
- pc_we_o  output  1  PC update strobe
- pc_sel_o  output  2  0=PC+4, 1=PC+imm, 2=rs1+imm
- alu_src_imm_o  output  1  ALU operand B is the immediate
- rf_we_o  output  1  register file write strobe
- rf_wsel_o  output  2  0=ALU, 1=load data, 2=PC+4
- retired_o  output  1  one-cycle pulse per retired instruction
- illegal_o  output  1  illegal opcode trap, sticky
- bus_error_o  output  1  handshake timeout trap, sticky

Function
REQ-003 SHALL be a Moore FSM with states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; every output SHALL be decoded from the state and the latched opcode/rd only, except branch_taken_i, which SHALL only affect pc_sel_o in EXECUTE.
REQ-004 IDLE SHALL drive all outputs to 0 and SHALL go to FETCH on the next edge.
REQ-005 FETCH SHALL drive imem_req_o=1; when imem_ready_i=1 it SHALL drive ir_we_o=1 that cycle, latch opcode instr_i[6:0] and rd instr_i[11:7], and go to DECODE.
REQ-006 DECODE SHALL go to EXECUTE for OP, OP_IMM, LOAD, STORE, BRANCH, JAL and JALR; any other opcode SHALL go to TRAP and set illegal_o.
REQ-007 EXECUTE SHALL drive alu_src_imm_o=1 for OP_IMM, LOAD, STORE and JALR, and 0 otherwise.
REQ-008 EXECUTE transitions:
- BRANCH: drive pc_we_o=1, pc_sel_o=1 if branch_taken_i else 0, retired_o=1, then go to FETCH.
- LOAD or STORE: go to MEMORY.
- All other classes: go to WRITEBACK.
REQ-009 MEMORY SHALL drive dmem_req_o=1 and dmem_we_o=1 for STORE; on dmem_ready_i=1 a STORE SHALL drive pc_we_o=1, pc_sel_o=0, retired_o=1 and go to FETCH, and a LOAD SHALL go to WRITEBACK.
REQ-010 WRITEBACK SHALL drive rf_we_o=1 unless rd=X0, rf_wsel_o=1 for LOAD, 2 for JAL/JALR and 0 otherwise, pc_we_o=1, pc_sel_o=1 for JAL, 2 for JALR and 0 otherwise, and retired_o=1, then go to FETCH.
REQ-011 With zero-wait memory, latency SHALL be 4 cycles for OP, OP_IMM, JAL and JALR, 3 cycles for BRANCH, 4 cycles for STORE and 5 cycles for LOAD, measured from the FETCH handshake cycle to the retired_o pulse inclusive.
REQ-012 imem_ready_i outside FETCH and dmem_ready_i outside MEMORY SHALL be ignored.
REQ-013 A request SHALL stay asserted until its ready arrives; the request SHALL NOT be dropped mid-wait.
REQ-014 TRAP SHALL hold all strobes at 0 and hold illegal_o/bus_error_o, and SHALL leave only on reset.

Reset
REQ-015 Reset assertion SHALL force IDLE immediately regardless of the current state, clear illegal_o, bus_error_o, the latched opcode/rd and the wait counter, and drive all outputs to 0.
REQ-016 First FETCH SHALL occur in the second cycle after rst_n deasserts.

Configuration
REQ-017 With CORE_CONTROL_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entering FETCH or MEMORY and increment each waiting cycle; if the count reaches MEM_TIMEOUT-1 without a ready, the FSM SHALL go to TRAP and set bus_error_o.
REQ-018 Without CORE_CONTROL_TIMEOUT_EN, waits SHALL be unbounded, no counter SHALL be synthesised, and bus_error_o SHALL be tied to 0.

Structure
REQ-019 The ctrl_state_t, pc_sel_t and wb_sel_t enums SHALL be added to riscv_pkg; opcode constants, the rd field indices and X0 SHALL be taken from riscv_pkg.
REQ-020 The wait counter SHALL be a sub-module, wait_timer, with parameter MEM_TIMEOUT, inputs clear/enable and output expired.

Verification
REQ-021 Release reset with imem_ready_i tied to 1 and feed ADDI x5 -> IDLE, FETCH, DECODE, EXECUTE, WRITEBACK; rf_we_o=1, rf_wsel_o=0, retired_o one pulse in the 5th cycle after reset release.
REQ-022 Feed LW x3 with dmem_ready_i delayed 3 cycles -> dmem_req_o held 4 cycles, dmem_we_o=0, then WRITEBACK with rf_wsel_o=1.
REQ-023 Feed BEQ with branch_taken_i=1, then again with branch_taken_i=0 -> pc_we_o in EXECUTE with pc_sel_o=1, then pc_sel_o=0; rf_we_o never asserted.
REQ-024 Feed ADD x0 and JAL x0 -> rf_we_o stays 0; JAL gives pc_sel_o=1.
REQ-025 Feed opcode 7'b1111111 -> TRAP, illegal_o=1 held for 20 cycles; rst_n low mid-TRAP clears it asynchronously.
REQ-026 With CORE_CONTROL_TIMEOUT_EN and MEM_TIMEOUT=4, hold imem_ready_i=0 -> bus_error_o=1 after 4 FETCH cycles; without the macro, imem_req_o stays 1 for 100 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : riscv_pkg                                                         |
// | Brief  : RV32I opcode/field constants and core control FSM enumerations.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    localparam int c_OPC_MSB = 6;
    localparam int c_OPC_LSB = 0;
    localparam int c_RD_MSB  = 11;
    localparam int c_RD_LSB  = 7;

    localparam logic [4:0] c_X0 = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_REL   = 2'd1,
        PC_RS1   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic legal;
        legal = 1'b0;
        case (opc)
            c_OPC_OP, c_OPC_OP_IMM, c_OPC_LOAD, c_OPC_STORE,
            c_OPC_BRANCH, c_OPC_JAL, c_OPC_JALR: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wait_timer.sv
// +----------------------------------------------------------------------------+
// | Module : wait_timer                                                        |
// | Brief  : 8-bit saturating handshake wait counter; expired at MEM_TIMEOUT-1.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_q, count_d;

    assign expired = (count_q == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable && !expired) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_control.sv
// +----------------------------------------------------------------------------+
// | Module : core_control                                                      |
// | Brief  : Multi-cycle RV32I control FSM. Define CORE_CONTROL_TIMEOUT_EN to  |
// |          trap on memory handshakes exceeding MEM_TIMEOUT cycles.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_control
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    output logic        imem_req_o,
    input  logic        imem_ready_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ready_i,
    input  logic        branch_taken_i,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        alu_src_imm_o,
    output logic        rf_we_o,
    output logic [1:0]  rf_wsel_o,
    output logic        retired_o,
    output logic        illegal_o,
    output logic        bus_error_o
);

    ctrl_state_t state_q, state_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [4:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d;
    logic        w_expired;
    logic        w_unused_instr;
    pc_sel_t     w_pc_sel;
    wb_sel_t     w_wb_sel;

    // Only opcode and rd are consumed here; the datapath decodes the rest.
    assign w_unused_instr = ^instr_i[31:c_RD_MSB+1];

    if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255)) begin : g_mem_timeout_range
        $error("core_control: MEM_TIMEOUT must be within 2..255");
    end

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        rd_d          = rd_q;
        illegal_d     = illegal_q;
        imem_req_o    = 1'b0;
        dmem_req_o    = 1'b0;
        dmem_we_o     = 1'b0;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        w_pc_sel      = PC_PLUS4;
        alu_src_imm_o = 1'b0;
        rf_we_o       = 1'b0;
        w_wb_sel      = WB_ALU;
        retired_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_we_o  = 1'b1;
                    opcode_d = instr_i[c_OPC_MSB:c_OPC_LSB];
                    rd_d     = instr_i[c_RD_MSB:c_RD_LSB];
                    state_d  = ST_DECODE;
                end else if (w_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(opcode_q)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXECUTE: begin
                alu_src_imm_o = (opcode_q == c_OPC_OP_IMM) || (opcode_q == c_OPC_LOAD) ||
                                (opcode_q == c_OPC_STORE)  || (opcode_q == c_OPC_JALR);
                if (opcode_q == c_OPC_BRANCH) begin
                    pc_we_o   = 1'b1;
                    w_pc_sel  = branch_taken_i ? PC_REL : PC_PLUS4;
                    retired_o = 1'b1;
                    state_d   = ST_FETCH;
                end else if ((opcode_q == c_OPC_LOAD) || (opcode_q == c_OPC_STORE)) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (opcode_q == c_OPC_STORE);
                if (dmem_ready_i) begin
                    if (opcode_q == c_OPC_STORE) begin
                        pc_we_o   = 1'b1;
                        retired_o = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (w_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WRITEBACK: begin
                rf_we_o   = (rd_q != c_X0);
                pc_we_o   = 1'b1;
                retired_o = 1'b1;
                state_d   = ST_FETCH;
                if (opcode_q == c_OPC_LOAD) begin
                    w_wb_sel = WB_LOAD;
                end else if ((opcode_q == c_OPC_JAL) || (opcode_q == c_OPC_JALR)) begin
                    w_wb_sel = WB_PC4;
                end
                if (opcode_q == c_OPC_JAL) begin
                    w_pc_sel = PC_REL;
                end else if (opcode_q == c_OPC_JALR) begin
                    w_pc_sel = PC_RS1;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pc_sel_o  = w_pc_sel;
    assign rf_wsel_o = w_wb_sel;
    assign illegal_o = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 7'd0;
            rd_q      <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef CORE_CONTROL_TIMEOUT_EN
    logic w_wait_active;
    logic bus_error_q, bus_error_d;

    assign w_wait_active = ((state_q == ST_FETCH)  && !imem_ready_i) ||
                           ((state_q == ST_MEMORY) && !dmem_ready_i);

    // Any state change restarts the count, so each wait phase starts from zero.
    wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_d != state_q),
        .enable  (w_wait_active),
        .expired (w_expired)
    );

    always_comb begin
        bus_error_d = bus_error_q | (w_wait_active & w_expired);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error_o = bus_error_q;
`else
    assign w_expired   = 1'b0;
    assign bus_error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_control.sv
// +----------------------------------------------------------------------------+
// | Module : tb_core_control                                                   |
// | Brief  : Self-checking bench for core_control (directed + random program). |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_core_control;

    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_JAL    = 7'b1101111;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        imem_req_o;
    logic        imem_ready_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ready_i;
    logic        branch_taken_i;
    logic        ir_we_o;
    logic        pc_we_o;
    logic [1:0]  pc_sel_o;
    logic        alu_src_imm_o;
    logic        rf_we_o;
    logic [1:0]  rf_wsel_o;
    logic        retired_o;
    logic        illegal_o;
    logic        bus_error_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    core_control #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_i        (instr_i),
        .imem_req_o     (imem_req_o),
        .imem_ready_i   (imem_ready_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_ready_i   (dmem_ready_i),
        .branch_taken_i (branch_taken_i),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .alu_src_imm_o  (alu_src_imm_o),
        .rf_we_o        (rf_we_o),
        .rf_wsel_o      (rf_wsel_o),
        .retired_o      (retired_o),
        .illegal_o      (illegal_o),
        .bus_error_o    (bus_error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outputs();
        return int'({imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o,
                     alu_src_imm_o, rf_we_o, rf_wsel_o, retired_o, illegal_o, bus_error_o});
    endfunction

    function automatic int strobes();
        return int'({imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o,
                     alu_src_imm_o, rf_we_o, retired_o});
    endfunction

    function automatic logic [31:0] make_instr(input logic [6:0] op, input logic [4:0] rd);
        logic [31:0] w;
        w       = $urandom;
        w[6:0]  = op;
        w[11:7] = rd;
        return w;
    endfunction

    // One instruction through the DUT; observations are compared against the
    // per-class behaviour (latency, strobes, selects) derived from the opcode.
    task automatic run_instr(input string name, input logic [31:0] instr,
                             input int iw, input int dw, input int br);
        logic [6:0] op;
        logic [4:0] rd;
        bit ld, st, bra, jal, jalr, writes, done;
        int cyc, h, r, fetch_n, mem_n, dwe_n, rfwe_n, wsel, pcwe_n, pcsel, imm_n, irwe_n, trap_n;
        int exp_lat, exp_sel, exp_wsel;
        logic taken;
        op = instr[6:0];
        rd = instr[11:7];
        ld = (op == c_LOAD);  st = (op == c_STORE); bra = (op == c_BRANCH);
        jal = (op == c_JAL);  jalr = (op == c_JALR);
        writes = (op == c_OP) || (op == c_OPIMM) || ld || jal || jalr;
        done = 1'b0; taken = 1'b0;
        cyc = 0; h = -100; r = -1; fetch_n = 0; mem_n = 0; dwe_n = 0; rfwe_n = 0; wsel = -1;
        pcwe_n = 0; pcsel = -1; imm_n = 0; irwe_n = 0; trap_n = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            instr_i        = $urandom;
            branch_taken_i = (br < 0) ? 1'($urandom) : br[0];
            #1;
            if (imem_req_o) begin
                imem_ready_i = (fetch_n >= iw);
                if (imem_ready_i) instr_i = instr;
                fetch_n++;
            end else begin
                imem_ready_i = 1'($urandom);
            end
            if (dmem_req_o) begin
                dmem_ready_i = (mem_n >= dw);
                mem_n++;
            end else begin
                dmem_ready_i = 1'($urandom);
            end
            #1;
            if (imem_req_o && imem_ready_i) h = cyc;
            if (ir_we_o) irwe_n++;
            if (dmem_we_o) dwe_n++;
            if (rf_we_o) begin rfwe_n++; wsel = int'(rf_wsel_o); end
            if (pc_we_o) begin pcwe_n++; pcsel = int'(pc_sel_o); taken = branch_taken_i; end
            if (alu_src_imm_o) imm_n++;
            if (illegal_o || bus_error_o) trap_n++;
            if (retired_o) begin r = cyc; done = 1'b1; end
            cyc++;
        end
        exp_lat  = bra ? 3 : ld ? 5 + dw : st ? 4 + dw : 4;
        exp_sel  = jal ? 1 : jalr ? 2 : bra ? int'(taken) : 0;
        exp_wsel = ld ? 1 : (jal || jalr) ? 2 : 0;
        check({name, " retired"}, int'(done), 1);
        check({name, " latency"}, r - h + 1, exp_lat);
        check({name, " imem_req cycles"}, fetch_n, iw + 1);
        check({name, " ir_we pulses"}, irwe_n, 1);
        check({name, " dmem_req cycles"}, mem_n, (ld || st) ? dw + 1 : 0);
        check({name, " dmem_we cycles"}, dwe_n, st ? dw + 1 : 0);
        check({name, " rf_we pulses"}, rfwe_n, (writes && rd != 5'd0) ? 1 : 0);
        if (writes && rd != 5'd0) check({name, " rf_wsel"}, wsel, exp_wsel);
        check({name, " pc_we pulses"}, pcwe_n, 1);
        check({name, " pc_sel"}, pcsel, exp_sel);
        check({name, " alu_src_imm cycles"}, imm_n, ((op == c_OPIMM) || ld || st || jalr) ? 1 : 0);
        check({name, " no trap"}, trap_n, 0);
    endtask

    logic [6:0] ops [7];

    initial begin
        logic [4:0] req_v, ret_v, rfwe_v, irwe_v;
        int wsel5, cnt, bad;
        logic [6:0] op;
        logic [4:0] rd;
        ops = '{c_OP, c_OPIMM, c_LOAD, c_STORE, c_BRANCH, c_JAL, c_JALR};

        rst_n = 1'b0; instr_i = '0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0; branch_taken_i = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset outputs", all_outputs(), 0);

        // ADDI x5 with imem always ready, released at a falling edge: cycle 1 is IDLE.
        instr_i = {12'h001, 5'd2, 3'b000, 5'd5, c_OPIMM};
        imem_ready_i = 1'b1;
        rst_n = 1'b1;
        req_v = '0; ret_v = '0; rfwe_v = '0; irwe_v = '0; wsel5 = -1;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 3) imem_ready_i = 1'b0;
            #1;
            req_v[k-1] = imem_req_o; ret_v[k-1] = retired_o;
            rfwe_v[k-1] = rf_we_o;   irwe_v[k-1] = ir_we_o;
            if (k == 5) wsel5 = int'(rf_wsel_o);
        end
        check("addi imem_req timing", int'(req_v), 'b00010);
        check("addi ir_we timing", int'(irwe_v), 'b00010);
        check("addi retired timing", int'(ret_v), 'b10000);
        check("addi rf_we timing", int'(rfwe_v), 'b10000);
        check("addi rf_wsel", wsel5, 0);

        run_instr("LW x3", {12'h004, 5'd1, 3'b010, 5'd3, c_LOAD}, 0, 3, -1);
        run_instr("BEQ taken", {7'h0, 5'd2, 5'd1, 3'b000, 5'd8, c_BRANCH}, 1, 0, 1);
        run_instr("BEQ not taken", {7'h0, 5'd2, 5'd1, 3'b000, 5'd8, c_BRANCH}, 0, 0, 0);
        run_instr("ADD x0", {7'h0, 5'd2, 5'd1, 3'b000, 5'd0, c_OP}, 0, 0, -1);
        run_instr("JAL x0", {20'h00010, 5'd0, c_JAL}, 2, 0, -1);
        run_instr("SW", make_instr(c_STORE, 5'd9), 0, 2, -1);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(6, 0)];
            rd = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom);
            run_instr($sformatf("rand%0d op=%b rd=%0d", i, op, rd), make_instr(op, rd),
                      $urandom_range(3, 0), $urandom_range(3, 0), -1);
        end

        // Illegal opcode: DUT is in FETCH right after the last retire.
        @(negedge clk); #1;
        check("illegal fetch req", int'(imem_req_o), 1);
        instr_i = {20'hABCDE, 5'd4, 7'b1111111}; imem_ready_i = 1'b1;
        @(negedge clk); imem_ready_i = 1'b0; #1;
        check("illegal not yet set in decode", int'(illegal_o), 0);
        cnt = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            imem_ready_i = 1'($urandom); dmem_ready_i = 1'($urandom);
            branch_taken_i = 1'($urandom); instr_i = $urandom;
            #1;
            if (illegal_o) cnt++;
            if (strobes() != 0 || bus_error_o) bad++;
        end
        check("illegal held 20 cycles", cnt, 20);
        check("trap strobes quiet", bad, 0);
        #2 rst_n = 1'b0;
        #1 check("async reset clears trap", all_outputs(), 0);
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        repeat (2) @(negedge clk);

        // Fetch that never completes.
        rst_n = 1'b1;
        cnt = 0;
`ifdef CORE_CONTROL_TIMEOUT_EN
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus_error_o) break;
            if (imem_req_o) cnt++;
        end
        check("timeout fetch cycles", cnt, 4);
        check("bus_error set", int'(bus_error_o), 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); imem_ready_i = 1'($urandom); #1;
            if (!bus_error_o || strobes() != 0 || illegal_o) bad++;
        end
        check("bus_error trap held", bad, 0);
`else
        bad = 0;
        for (int k = 0; k < 101; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (imem_req_o) cnt++;
            if (bus_error_o) bad++;
        end
        check("unbounded fetch req cycles", cnt, 100);
        check("bus_error stays 0", bad, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
